// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release after hold time and filtered PLL lock
//
// Purpose: holds all stage resets for HOLD_CNT cycles, waits for LOCK_FILTER
// consecutive PLL_LOCKED samples, then releases RST_STAGE[0..NSTAGES-1] one per
// STAGE_DLY cycles. Lock loss or a soft request after release has begun restarts
// the whole sequence.
// Optional feature macro: RESET_SEQ_STATUS_EN (adds RESTART_CNT and LAST_CAUSE).
//
// Ports:
//   CLK          in   clock, rising edge
//   RST_N        in   synchronous active-low reset
//   PLL_LOCKED   in   PLL lock flag, synchronous to CLK
//   SOFT_RST_REQ in   1 = request full re-sequence
//   RST_STAGE    out  active-high stage resets, bit 0 released first
//   READY        out  all stages released
//   BUSY         out  sequence not in RUN
//   RESTART_CNT  out  saturating restart count (status build only)
//   LAST_CAUSE   out  01 lock loss, 10 soft request (status build only)

module reset_sequencer #(
  parameter int NSTAGES     = 4,
  parameter int HOLD_CNT    = 16,
  parameter int LOCK_FILTER = 4,
  parameter int STAGE_DLY   = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               PLL_LOCKED,
  input  logic               SOFT_RST_REQ,
  output logic [NSTAGES-1:0] RST_STAGE,
  output logic               READY,
  output logic               BUSY
`ifdef RESET_SEQ_STATUS_EN
  ,
  output logic [7:0]         RESTART_CNT,
  output logic [1:0]         LAST_CAUSE
`endif
);

  localparam int IDXW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam logic [15:0]     HOLD_LAST = 16'(HOLD_CNT - 1);
  localparam logic [15:0]     FILT_LAST = 16'(LOCK_FILTER - 1);
  localparam logic [15:0]     DLY_LAST  = 16'(STAGE_DLY - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NSTAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         hold_cnt_q, hold_cnt_d;
  logic [15:0]         filt_q, filt_d;
  logic [15:0]         dly_q, dly_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [NSTAGES-1:0]  rst_stage_q, rst_stage_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                restart;
  logic                lock_loss;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    filt_d      = filt_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    rst_stage_d = rst_stage_q;
    restart     = 1'b0;
    lock_loss   = !PLL_LOCKED;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_WAIT_LOCK;
          hold_cnt_d = '0;
          filt_d     = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (!PLL_LOCKED) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = S_RELEASE;
          filt_d  = '0;
          idx_d   = '0;
          dly_d   = '0;
        end else begin
          filt_d = filt_q + 16'd1;
        end
      end
      S_RELEASE: begin
        // A restart request wins over a stage release due on the same edge.
        if (lock_loss || SOFT_RST_REQ) begin
          restart = 1'b1;
        end else if (dly_q == DLY_LAST) begin
          dly_d = '0;
          for (int i = 0; i < NSTAGES; i++) begin
            if (IDXW'(i) == idx_q) rst_stage_d[i] = 1'b0;
          end
          if (idx_q == IDX_LAST) state_d = S_RUN;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      S_RUN: begin
        if (lock_loss || SOFT_RST_REQ) restart = 1'b1;
      end
      default: state_d = S_HOLD;
    endcase

    // Re-assert every stage at once so downstream blocks never see a partial reset.
    if (restart) begin
      state_d     = S_HOLD;
      hold_cnt_d  = '0;
      filt_d      = '0;
      dly_d       = '0;
      idx_d       = '0;
      rst_stage_d = '1;
    end

    ready_d = (state_d == S_RUN);
    busy_d  = (state_d != S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      filt_q      <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      rst_stage_q <= '1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      filt_q      <= filt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      rst_stage_q <= rst_stage_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign RST_STAGE = rst_stage_q;
  assign READY     = ready_q;
  assign BUSY      = busy_q;

`ifdef RESET_SEQ_STATUS_EN
  logic [7:0] restart_cnt_q, restart_cnt_d;
  logic [1:0] last_cause_q, last_cause_d;

  always_comb begin
    restart_cnt_d = restart_cnt_q;
    last_cause_d  = last_cause_q;
    if (restart) begin
      if (restart_cnt_q != 8'hFF) restart_cnt_d = restart_cnt_q + 8'd1;
      // Lock loss is reported when both causes coincide.
      last_cause_d = lock_loss ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      restart_cnt_q <= '0;
      last_cause_q  <= '0;
    end else begin
      restart_cnt_q <= restart_cnt_d;
      last_cause_q  <= last_cause_d;
    end
  end

  assign RESTART_CNT = restart_cnt_q;
  assign LAST_CAUSE  = last_cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer

module tb_reset_sequencer;

  localparam int NSTAGES     = 4;
  localparam int HOLD_CNT    = 16;
  localparam int LOCK_FILTER = 4;
  localparam int STAGE_DLY   = 8;

  logic               CLK;
  logic               RST_N;
  logic               PLL_LOCKED;
  logic               SOFT_RST_REQ;
  logic [NSTAGES-1:0] RST_STAGE;
  logic               READY;
  logic               BUSY;
`ifdef RESET_SEQ_STATUS_EN
  logic [7:0]         RESTART_CNT;
  logic [1:0]         LAST_CAUSE;
`endif

  reset_sequencer #(
    .NSTAGES(NSTAGES), .HOLD_CNT(HOLD_CNT),
    .LOCK_FILTER(LOCK_FILTER), .STAGE_DLY(STAGE_DLY)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PLL_LOCKED(PLL_LOCKED), .SOFT_RST_REQ(SOFT_RST_REQ),
    .RST_STAGE(RST_STAGE), .READY(READY), .BUSY(BUSY)
`ifdef RESET_SEQ_STATUS_EN
    , .RESTART_CNT(RESTART_CNT), .LAST_CAUSE(LAST_CAUSE)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs as seen by the active edge, plus edge numbering since reset release.
  logic s_rst, s_pll, s_soft;
  int   ecount = 0;
  always @(posedge CLK) begin
    s_rst  <= RST_N;
    s_pll  <= PLL_LOCKED;
    s_soft <= SOFT_RST_REQ;
    ecount <= RST_N ? ecount + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Behavioural model: time-based view of the sequence.
  // hold_n edges spent in hold, lock_n consecutive locked samples while waiting,
  // rel_t edges since release began; stages released = rel_t / STAGE_DLY.
  bit model_valid = 0;
  bit waiting, in_rel;
  int hold_n, lock_n, rel_t, m_restarts, m_cause;

  initial begin
    logic [NSTAGES-1:0] e_stage;
    int released;
    forever begin
      @(negedge CLK);
      if (s_rst === 1'b0) begin
        model_valid = 1; waiting = 0; in_rel = 0;
        hold_n = 0; lock_n = 0; rel_t = 0; m_restarts = 0; m_cause = 0;
      end else if (model_valid) begin
        if (in_rel && (!s_pll || s_soft)) begin
          in_rel = 0; waiting = 0; hold_n = 0; lock_n = 0; rel_t = 0;
          if (m_restarts < 255) m_restarts++;
          m_cause = !s_pll ? 1 : 2;
        end else if (in_rel) begin
          if (rel_t < NSTAGES * STAGE_DLY) rel_t++;
        end else if (!waiting) begin
          hold_n++;
          if (hold_n == HOLD_CNT) begin waiting = 1; lock_n = 0; end
        end else begin
          lock_n = s_pll ? lock_n + 1 : 0;
          if (lock_n == LOCK_FILTER) begin in_rel = 1; waiting = 0; rel_t = 0; end
        end
      end
      if (model_valid) begin
        released = in_rel ? rel_t / STAGE_DLY : 0;
        e_stage  = '1;
        for (int i = 0; i < NSTAGES; i++) if (i < released) e_stage[i] = 1'b0;
        check("model_rst_stage", 32'(RST_STAGE), 32'(e_stage));
        check("model_ready", 32'(READY), 32'(released == NSTAGES));
        check("model_busy", 32'(BUSY), 32'(released != NSTAGES));
`ifdef RESET_SEQ_STATUS_EN
        check("model_restart_cnt", 32'(RESTART_CNT), 32'(m_restarts));
        check("model_last_cause", 32'(LAST_CAUSE), 32'(m_cause));
`endif
      end
    end
  end

  task automatic goto_edge(input int n);
    int guard = 0;
    while (ecount < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (ecount != n) begin
      miscompares++;
      $display("FAIL goto_edge: reached %0d wanted %0d", ecount, n);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; SOFT_RST_REQ = 1'b0; PLL_LOCKED = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; PLL_LOCKED = 1'b1; SOFT_RST_REQ = 1'b0;

    // Nominal sequence with lock held.
    do_reset();
    check("reset_stage", 32'(RST_STAGE), 32'hF);
    check("reset_ready", 32'(READY), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h1);
    goto_edge(27); check("t1_e27", 32'(RST_STAGE), 32'hF);
    goto_edge(28); check("t1_e28", 32'(RST_STAGE), 32'hE);
    goto_edge(35); check("t1_e35", 32'(RST_STAGE), 32'hE);
    goto_edge(36); check("t1_e36", 32'(RST_STAGE), 32'hC);
    goto_edge(44); check("t1_e44", 32'(RST_STAGE), 32'h8);
    goto_edge(51); check("t1_e51_ready", 32'(READY), 32'h0);
    goto_edge(52);
    check("t1_e52_stage", 32'(RST_STAGE), 32'h0);
    check("t1_e52_ready", 32'(READY), 32'h1);
    check("t1_e52_busy", 32'(BUSY), 32'h0);

    // Lock loss in RUN for one edge E=61.
    goto_edge(60);
    PLL_LOCKED = 1'b0;
    @(negedge CLK);
    PLL_LOCKED = 1'b1;
    check("t3_stage", 32'(RST_STAGE), 32'hF);
    check("t3_ready", 32'(READY), 32'h0);
`ifdef RESET_SEQ_STATUS_EN
    check("t3_cnt", 32'(RESTART_CNT), 32'h1);
    check("t3_cause", 32'(LAST_CAUSE), 32'h1);
`endif
    goto_edge(112); check("t3_e112_ready", 32'(READY), 32'h0);
    goto_edge(113); check("t3_e113_ready", 32'(READY), 32'h1);

    // Lock glitch sampled at edge 18 during the lock filter.
    do_reset();
    goto_edge(17); PLL_LOCKED = 1'b0;
    goto_edge(18); PLL_LOCKED = 1'b1;
    goto_edge(29); check("t2_e29", 32'(RST_STAGE), 32'hF);
    goto_edge(30); check("t2_e30", 32'(RST_STAGE), 32'hE);
    goto_edge(53); check("t2_e53_ready", 32'(READY), 32'h0);
    goto_edge(54); check("t2_e54_ready", 32'(READY), 32'h1);

    // Soft request sampled at edge 30, after bit 0 released.
    do_reset();
    goto_edge(29); check("t4_e29", 32'(RST_STAGE), 32'hE);
    SOFT_RST_REQ = 1'b1;
    goto_edge(30); SOFT_RST_REQ = 1'b0;
    goto_edge(31); check("t4_e31", 32'(RST_STAGE), 32'hF);
`ifdef RESET_SEQ_STATUS_EN
    check("t4_cause", 32'(LAST_CAUSE), 32'h2);
`endif
    goto_edge(81); check("t4_e81_ready", 32'(READY), 32'h0);
    goto_edge(82); check("t4_e82_ready", 32'(READY), 32'h1);

    // Reset at edge 40 together with a soft request.
    do_reset();
    goto_edge(39);
    RST_N = 1'b0; SOFT_RST_REQ = 1'b1;
    @(negedge CLK);
    check("t5_stage", 32'(RST_STAGE), 32'hF);
    check("t5_ready", 32'(READY), 32'h0);
    check("t5_busy", 32'(BUSY), 32'h1);
`ifdef RESET_SEQ_STATUS_EN
    check("t5_cnt", 32'(RESTART_CNT), 32'h0);
`endif
    RST_N = 1'b1; SOFT_RST_REQ = 1'b0;

    // Lock loss and soft request together from RUN.
    do_reset();
    goto_edge(60);
    PLL_LOCKED = 1'b0; SOFT_RST_REQ = 1'b1;
    @(negedge CLK);
    PLL_LOCKED = 1'b1; SOFT_RST_REQ = 1'b0;
    check("t6_both_stage", 32'(RST_STAGE), 32'hF);
`ifdef RESET_SEQ_STATUS_EN
    check("t6_both_cnt", 32'(RESTART_CNT), 32'h1);
    check("t6_both_cause", 32'(LAST_CAUSE), 32'h1);

    // Saturation: many soft restarts from RUN.
    repeat (53) @(negedge CLK);
    for (int k = 0; k < 300; k++) begin
      SOFT_RST_REQ = 1'b1;
      @(negedge CLK);
      SOFT_RST_REQ = 1'b0;
      repeat (52) @(negedge CLK);
    end
    check("t6_sat_cnt", 32'(RESTART_CNT), 32'hFF);
    check("t6_sat_cause", 32'(LAST_CAUSE), 32'h2);
    check("t6_sat_ready", 32'(READY), 32'h1);
`endif

    // Randomized stimulus against the model, two lock-quality regimes.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int c = 0; c < 2500; c++) begin
        @(negedge CLK);
        PLL_LOCKED   = (phase == 0) ? ($urandom_range(0, 29) != 0)
                                    : ($urandom_range(0, 299) != 0);
        SOFT_RST_REQ = ($urandom_range(0, 199) == 0);
        RST_N        = ($urandom_range(0, 1499) != 0);
      end
    end

    @(negedge CLK);
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
